// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt pending controller.
package irq_pkg;
    localparam int unsigned N_IRQ      = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned MODE_LEVEL = 0;
    localparam int unsigned MODE_EDGE  = 1;

    typedef logic [N_IRQ-1:0] irq_vec_t;
    typedef logic [IDX_W-1:0] irq_idx_t;

    function automatic irq_vec_t onehot8(input irq_idx_t idx);
        irq_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/irq_pend_ctrl_if.sv
// Valid/ready channel carrying the selected interrupt ID downstream.
interface irq_pend_ctrl_if;
    logic                      irq_valid;
    logic [irq_pkg::IDX_W-1:0] irq_id;
    logic                      irq_ready;

    modport master (output irq_valid, output irq_id, input irq_ready);
    modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/irq_prio_sel.sv
// Combinational highest-index selector over an 8-bit request vector.
module irq_prio_sel
    import irq_pkg::*;
(
    input  irq_vec_t vec,
    output irq_idx_t idx,
    output logic     any
);
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        any = |vec;
    end
endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt pending controller: sync, event detect, pending bits, and a
// registered valid/ready ID presenter with highest-index priority.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IRQ-1:0]       irq_in,
    input  logic [N_IRQ-1:0]       irq_mask,
    input  logic                   en,
    irq_pend_ctrl_if.master        irq_bus,
    output logic                   irq_any,
    output logic                   irq_none,
    output logic [N_IRQ-1:0]       pending
);
    irq_vec_t sync_q [SYNC_STAGES];
    irq_vec_t sync_d [SYNC_STAGES];
    irq_vec_t s_dly_q, s_dly_d;
    irq_vec_t pending_q, pending_d;
    logic     valid_q, valid_d;
    irq_idx_t id_q, id_d;

    irq_vec_t s, ev, clr, cand;
    logic     acc, cand_any;
    irq_idx_t cand_idx;

    always_comb begin
        sync_d[0] = irq_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign s_dly_d = s;
    assign ev      = (EDGE_MODE == MODE_EDGE) ? (s & ~s_dly_q) : s;
    assign acc     = valid_q & irq_bus.irq_ready;
    assign clr     = acc ? onehot8(id_q) : '0;
    // The accepted line is excluded so the reload does not re-present it.
    assign cand    = pending_q & irq_mask & ~clr;

    irq_prio_sel u_sel (
        .vec (cand),
        .idx (cand_idx),
        .any (cand_any)
    );

    always_comb begin
        pending_d = ev | (pending_q & ~clr);
        valid_d   = valid_q;
        id_d      = id_q;
        if (!valid_q || acc) begin
            valid_d = en & cand_any;
            id_d    = cand_idx;
        end else if (!en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            s_dly_q   <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            s_dly_q   <= s_dly_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
        end
    end

    assign irq_bus.irq_valid = valid_q;
    assign irq_bus.irq_id    = id_q;
    assign pending           = pending_q;
    assign irq_any           = en & |(pending_q & irq_mask);
    assign irq_none          = en & ~irq_any;
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl: an edge-mode instance for most scenarios
// and a level-mode instance for continuous re-presentation.
module tb_irq_pend_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in, irq_mask, pending;
    logic       en, irq_any, irq_none;
    logic [7:0] in2, mask2, pending2;
    logic       en2, any2, none2;

    int vectors    = 0;
    int miscompares = 0;

    irq_pend_ctrl_if bus ();
    irq_pend_ctrl_if bus2 ();

    irq_pend_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask), .en(en),
        .irq_bus(bus.master), .irq_any(irq_any), .irq_none(irq_none), .pending(pending)
    );

    irq_pend_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .irq_in(in2), .irq_mask(mask2), .en(en2),
        .irq_bus(bus2.master), .irq_any(any2), .irq_none(none2), .pending(pending2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; irq_in = 8'hFF; irq_mask = 8'hFF; bus.irq_ready = 1'b0;
        in2 = 8'h00; mask2 = 8'hFF; en2 = 1'b1; bus2.irq_ready = 1'b0;
        tick(2);
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL rst_pending: got %h expected 00", pending); end
        vectors++; if (bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", bus.irq_valid); end
        vectors++; if (bus.irq_id !== 3'd0) begin miscompares++; $display("FAIL rst_id: got %0d expected 0", bus.irq_id); end
        vectors++; if (irq_any !== 1'b0) begin miscompares++; $display("FAIL rst_any: got %b expected 0", irq_any); end
        vectors++; if (irq_none !== 1'b1) begin miscompares++; $display("FAIL rst_none: got %b expected 1", irq_none); end
        irq_in = 8'h00; rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single_edge;
        irq_in = 8'h20;
        tick(1);
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL se_pend_k: got %h expected 00", pending); end
        tick(1);
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL se_pend_k1: got %h expected 00", pending); end
        tick(1);
        vectors++; if (pending !== 8'h20) begin miscompares++; $display("FAIL se_pend_k2: got %h expected 20", pending); end
        vectors++; if (bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL se_valid_k2: got %b expected 0", bus.irq_valid); end
        tick(1);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd5) begin miscompares++; $display("FAIL se_present_k3: got v=%b id=%0d expected v=1 id=5", bus.irq_valid, bus.irq_id); end
        vectors++; if (irq_any !== 1'b1) begin miscompares++; $display("FAIL se_any: got %b expected 1", irq_any); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd5) begin miscompares++; $display("FAIL se_hold[%0d]: got v=%b id=%0d expected v=1 id=5", i, bus.irq_valid, bus.irq_id); end
        end
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h00 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL se_accept: got p=%h v=%b expected p=00 v=0", pending, bus.irq_valid); end
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_priority;
        logic [2:0] exp_id [3];
        logic [7:0] exp_p  [3];
        exp_id = '{3'd7, 3'd1, 3'd0};
        exp_p  = '{8'h82, 8'h02, 8'h00};
        irq_in = 8'h12;
        tick(4);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin miscompares++; $display("FAIL pr_first: got v=%b id=%0d expected v=1 id=4", bus.irq_valid, bus.irq_id); end
        irq_in = 8'h92;
        tick(4);
        vectors++; if (pending !== 8'h92) begin miscompares++; $display("FAIL pr_pend: got %h expected 92", pending); end
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin miscompares++; $display("FAIL pr_no_preempt: got v=%b id=%0d expected v=1 id=4", bus.irq_valid, bus.irq_id); end
        bus.irq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            vectors++; if (pending !== exp_p[i]) begin miscompares++; $display("FAIL pr_pend[%0d]: got %h expected %h", i, pending, exp_p[i]); end
            vectors++; if (bus.irq_valid !== (i < 2) || bus.irq_id !== exp_id[i]) begin miscompares++; $display("FAIL pr_order[%0d]: got v=%b id=%0d expected v=%b id=%0d", i, bus.irq_valid, bus.irq_id, (i < 2), exp_id[i]); end
        end
        bus.irq_ready = 1'b0;
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_id [4];
        exp_id = '{3'd5, 3'd3, 3'd2, 3'd0};
        bus.irq_ready = 1'b1;
        irq_in = 8'h2C;
        tick(3);
        vectors++; if (pending !== 8'h2C || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_pend: got p=%h v=%b expected p=2c v=0", pending, bus.irq_valid); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            vectors++; if (bus.irq_valid !== (i < 3) || bus.irq_id !== exp_id[i]) begin miscompares++; $display("FAIL b2b[%0d]: got v=%b id=%0d expected v=%b id=%0d", i, bus.irq_valid, bus.irq_id, (i < 3), exp_id[i]); end
        end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL b2b_drain: got %h expected 00", pending); end
        bus.irq_ready = 1'b0;
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_masking;
        irq_mask = 8'h01;
        irq_in = 8'h81;
        tick(4);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd0) begin miscompares++; $display("FAIL mk_id0: got v=%b id=%0d expected v=1 id=0", bus.irq_valid, bus.irq_id); end
        vectors++; if (irq_any !== 1'b1) begin miscompares++; $display("FAIL mk_any1: got %b expected 1", irq_any); end
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h80 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL mk_after_acc: got p=%h v=%b expected p=80 v=0", pending, bus.irq_valid); end
        vectors++; if (irq_any !== 1'b0 || irq_none !== 1'b1) begin miscompares++; $display("FAIL mk_masked_or: got any=%b none=%b expected any=0 none=1", irq_any, irq_none); end
        irq_mask = 8'hFF;
        #1;
        vectors++; if (irq_any !== 1'b1 || irq_none !== 1'b0) begin miscompares++; $display("FAIL mk_unmasked_or: got any=%b none=%b expected any=1 none=0", irq_any, irq_none); end
        tick(1);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin miscompares++; $display("FAIL mk_id7: got v=%b id=%0d expected v=1 id=7", bus.irq_valid, bus.irq_id); end
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h00 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL mk_drain: got p=%h v=%b expected p=00 v=0", pending, bus.irq_valid); end
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_set_clear;
        irq_in = 8'h08;
        tick(4);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin miscompares++; $display("FAIL sc_present: got v=%b id=%0d expected v=1 id=3", bus.irq_valid, bus.irq_id); end
        irq_in = 8'h00;
        tick(3);
        irq_in = 8'h08;
        tick(2);
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h08 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL sc_set_wins: got p=%h v=%b expected p=08 v=0", pending, bus.irq_valid); end
        tick(1);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin miscompares++; $display("FAIL sc_represent: got v=%b id=%0d expected v=1 id=3", bus.irq_valid, bus.irq_id); end
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h00 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL sc_drain: got p=%h v=%b expected p=00 v=0", pending, bus.irq_valid); end
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_en_abort;
        irq_in = 8'h04;
        tick(4);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin miscompares++; $display("FAIL ea_present: got v=%b id=%0d expected v=1 id=2", bus.irq_valid, bus.irq_id); end
        en = 1'b0;
        #1;
        vectors++; if (irq_any !== 1'b0 || irq_none !== 1'b0) begin miscompares++; $display("FAIL ea_status: got any=%b none=%b expected any=0 none=0", irq_any, irq_none); end
        tick(1);
        vectors++; if (bus.irq_valid !== 1'b0 || pending !== 8'h04) begin miscompares++; $display("FAIL ea_abort: got v=%b p=%h expected v=0 p=04", bus.irq_valid, pending); end
        en = 1'b1;
        tick(1);
        vectors++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin miscompares++; $display("FAIL ea_resume: got v=%b id=%0d expected v=1 id=2", bus.irq_valid, bus.irq_id); end
        bus.irq_ready = 1'b1;
        tick(1);
        bus.irq_ready = 1'b0;
        vectors++; if (pending !== 8'h00 || bus.irq_valid !== 1'b0) begin miscompares++; $display("FAIL ea_drain: got p=%h v=%b expected p=00 v=0", pending, bus.irq_valid); end
        irq_in = 8'h00;
        tick(3);
    endtask

    task automatic test_level;
        logic       exp_v;
        logic [2:0] exp_i;
        in2 = 8'h04;
        bus2.irq_ready = 1'b1;
        tick(3);
        vectors++; if (pending2 !== 8'h04 || bus2.irq_valid !== 1'b0) begin miscompares++; $display("FAIL lv_pend: got p=%h v=%b expected p=04 v=0", pending2, bus2.irq_valid); end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            exp_v = ((i % 2) == 0);
            exp_i = exp_v ? 3'd2 : 3'd0;
            vectors++; if (bus2.irq_valid !== exp_v || bus2.irq_id !== exp_i) begin miscompares++; $display("FAIL lv_repeat[%0d]: got v=%b id=%0d expected v=%b id=%0d", i, bus2.irq_valid, bus2.irq_id, exp_v, exp_i); end
            vectors++; if (pending2 !== 8'h04) begin miscompares++; $display("FAIL lv_pend[%0d]: got %h expected 04", i, pending2); end
        end
        bus2.irq_ready = 1'b0;
        in2 = 8'h00;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_back_to_back();
        test_masking();
        test_set_clear();
        test_en_abort();
        test_level();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
